clause_literal_fetcher: RTL
===========================

Name: clause_literal_fetcher

Overview:
- Upstream feeder of the per-flip temporal buffer array.
- On a start pulse, takes the NSAT candidate variables of the selected broken clause and walks the clause-table memory: MCPV slot reads per candidate, one read per cycle, fully pipelined.
- Assembles each candidate's (NSAT-1)*MCPV literals into one packed vector and pulses a write with the candidate index, so the buffer array holds all NSAT candidates' literals before the heuristic selector picks one.

Parameters:
- NSAT, 3, literals per clause; also the number of candidates.
- LAW, 11, literal address width; one literal is LAW+1 bits (polarity MSB + address).
- MCPV, 20, max clauses per variable; the number of slot reads per candidate.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start_i  input  1  start request; sampled only in IDLE
- candidate_vars_i  input  NSAT*LAW  candidate variable addresses; candidate c is at [c*LAW +: LAW]
- mem_req_o  output  1  clause-table read strobe
- mem_addr_o  output  LAW+SB  read address {var, slot}; SB = max(1, $clog2(MCPV))
- mem_data_i  input  (NSAT-1)*(LAW+1)  read data; valid exactly 1 cycle after mem_req_o
- write_index_o  output  $clog2(NSAT)  candidate index for the buffer write
- write_en_o  output  1  one-cycle buffer write strobe
- literals_multi_o  output  (NSAT-1)*MCPV*(LAW+1)  assembled literals; slot s at [s*(NSAT-1)*(LAW+1) +: (NSAT-1)*(LAW+1)]
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle pulse, coincident with the final write_en_o

Behaviour:
- Reset (synchronous, active-high): every output is 0, the FSM goes to IDLE, the assembly register and the data-valid pipe stage are cleared.
- Reset mid-operation aborts the walk. Memory data arriving in the cycle after reset is discarded, and no write_en_o is issued for a partial candidate.
- FSM states and transitions:
  - IDLE: start_i=1 at cycle T latches candidate_vars_i, clears the counters (c=0, s=0), moves to FETCH and sets busy_o from T+1.
  - FETCH: runs cycles T+1 .. T+NSAT*MCPV. Each cycle drives mem_req_o=1 and mem_addr_o={var[c], s}. s increments; when s=MCPV-1, s wraps to 0 and c increments. The cycle issuing (NSAT-1, MCPV-1) moves to DRAIN.
  - DRAIN: one cycle (T+NSAT*MCPV+1) that captures the final data beat, with mem_req_o=0. Then moves to FLUSH.
  - FLUSH: one cycle (T+NSAT*MCPV+2). Presents the final write and done_o=1, then returns to IDLE. busy_o drops at T+NSAT*MCPV+3.
- Data path:
  - A 1-cycle valid/slot/candidate pipe tags each returning beat.
  - A beat for slot s is written into slot s of the assembly register.
  - When a beat carries slot MCPV-1, the full vector (the assembly register with the final beat merged) loads the output register at that clock edge. write_en_o=1 and write_index_o=c follow in the next cycle.
  - Candidate c writes at cycle T+(c+1)*MCPV+2. Writes are spaced MCPV cycles apart, so with MCPV=1 they occur on consecutive cycles.
  - The assembly register may be overwritten by the next candidate's slot 0 in the same cycle that the output register is presented; the output register is separate to allow this.
- literals_multi_o and write_index_o hold their last values between writes. write_en_o and done_o are 0 except on their pulse cycles.
- start_i is ignored while busy_o=1, including in the FLUSH cycle. Back-to-back operation is possible: start_i in the first IDLE cycle after FLUSH is accepted.
- mem_data_i is opaque: all-zero (null) slots are stored unchanged, with no skipping and no early termination.
- Total latency from start to done_o is NSAT*MCPV+2 cycles.

Test Plan:
- Reset values: assert reset 3 cycles -> all outputs 0. start_i=1 while reset=1 -> no mem_req_o.
- Nominal walk (NSAT=3, MCPV=2, LAW=11): candidates {5,9,12}, memory model returns {var,slot} replicated, start at cycle 0.
  - mem_addr_o sequence over cycles 1-6: {5,0},{5,1},{9,0},{9,1},{12,0},{12,1}.
  - write_en_o at cycles 4,6,8 with index 0,1,2, each with correctly packed slots.
  - done_o at cycle 8; busy_o low at cycle 9.
- MCPV=1 edge (NSAT=3): writes on consecutive cycles 3,4,5, each with the correct single slot.
- Ignored start: pulse start_i again at cycle 3 -> no restart, and the addresses match the nominal run.
- Back-to-back: start_i at cycle 9 with new candidates -> second walk starts at cycle 10; no stale data appears in the first write.
- Mid-op reset: reset at cycle 3 of the nominal run -> no write_en_o at cycle 4 or later. A fresh start then yields fully correct vectors, with no leftover slots.

Source files
------------

// File: rtl/clause_literal_fetcher.sv
// rtl/clause_literal_fetcher.sv - walks the clause table for each broken-clause candidate and packs its literals
//
// Purpose:
//   On start_i, latches the NSAT candidate variable addresses of the selected
//   broken clause. For each candidate it issues MCPV back-to-back slot reads
//   ({var, slot}) to the clause-table memory. It then packs the returned
//   (NSAT-1)*(LAW+1)-bit beats into one vector per candidate and pulses a
//   buffer write tagged with that candidate's index.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start_i             start request, sampled only while idle
//   candidate_vars_i    NSAT packed variable addresses, candidate c at [c*LAW +: LAW]
//   mem_req_o           clause-table read strobe
//   mem_addr_o          read address {var, slot}
//   mem_data_i          read data, valid one cycle after mem_req_o
//   write_index_o       candidate index of the current buffer write
//   write_en_o          one-cycle buffer write strobe
//   literals_multi_o    assembled literals, slot s at [s*BW +: BW]
//   busy_o              walk in progress
//   done_o              one-cycle pulse alongside the final write_en_o

module clause_literal_fetcher #(
  parameter int NSAT = 3,
  parameter int LAW  = 11,
  parameter int MCPV = 20,
  localparam int SB   = (MCPV > 1) ? $clog2(MCPV) : 1,
  localparam int IW   = (NSAT > 1) ? $clog2(NSAT) : 1,
  localparam int BW   = (NSAT - 1) * (LAW + 1),
  localparam int VW   = MCPV * BW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [NSAT*LAW-1:0]  candidate_vars_i,
  output logic                 mem_req_o,
  output logic [LAW+SB-1:0]    mem_addr_o,
  input  logic [BW-1:0]        mem_data_i,
  output logic [IW-1:0]        write_index_o,
  output logic                 write_en_o,
  output logic [VW-1:0]        literals_multi_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [SB-1:0] S_LAST = SB'(MCPV - 1);
  localparam logic [IW-1:0] C_LAST = IW'(NSAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state_q;
  logic [NSAT*LAW-1:0] vars_q;
  logic [IW-1:0]       c_q;
  logic [SB-1:0]       s_q;

  // One-cycle tag pipe: describes the beat arriving on mem_data_i this cycle.
  logic                vld_q;
  logic [SB-1:0]       pslot_q;
  logic [IW-1:0]       pcand_q;

  logic [VW-1:0]       asm_q;
  logic [VW-1:0]       asm_d;
  logic [VW-1:0]       out_q;
  logic [IW-1:0]       idx_q;
  logic                we_q;
  logic                done_q;
  logic                busy_q;

  // Assembly register with the current beat merged in. The output register
  // loads from this on the last slot, so the final beat never has to pass
  // through asm_q first.
  always_comb begin
    asm_d = asm_q;
    asm_d[pslot_q*BW +: BW] = mem_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vars_q  <= '0;
      c_q     <= '0;
      s_q     <= '0;
      vld_q   <= 1'b0;
      pslot_q <= '0;
      pcand_q <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      done_q  <= 1'b0;

      vld_q   <= (state_q == FETCH);
      pslot_q <= s_q;
      pcand_q <= c_q;

      if (vld_q) begin
        asm_q <= asm_d;
        if (pslot_q == S_LAST) begin
          out_q <= asm_d;
          idx_q <= pcand_q;
          we_q  <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            vars_q  <= candidate_vars_i;
            c_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (s_q == S_LAST) begin
            s_q <= '0;
            if (c_q == C_LAST) begin
              state_q <= DRAIN;
            end else begin
              c_q <= c_q + 1'b1;
            end
          end else begin
            s_q <= s_q + 1'b1;
          end
        end
        DRAIN: begin
          // The last beat lands this cycle; its write and done appear together next cycle.
          done_q  <= 1'b1;
          state_q <= FLUSH;
        end
        FLUSH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o        = (state_q == FETCH);
  assign mem_addr_o       = mem_req_o ? {vars_q[c_q*LAW +: LAW], s_q} : '0;
  assign write_index_o    = idx_q;
  assign write_en_o       = we_q;
  assign literals_multi_o = out_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule
